// File: rtl/instruction_fetch_stage_pkg.sv
// Shared pipeline package for the MIPS fetch stage.
// Holds the datapath word width, the default reset PC and bubble word,
// and the IF/ID pipeline-register bundle.
package pipeline_pkg;

  localparam int WORD_W = 32;

  // sll $0,$0,0 : the canonical MIPS no-op used for bubbles
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;
  localparam logic [WORD_W-1:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] instruction;
    logic [WORD_W-1:0] pc_plus4;
    logic              valid;
  } ifid_t;

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Signal bundle between the fetch stage and its surroundings
// (pipeline control, instruction memory, decode stage).
//
// Control semantics: Stall, Flush, Redirect and RedirectPC are plain
// level signals sampled on each rising clock edge; there is no
// valid/ready handshake and no multi-cycle transaction. IFID_Valid
// qualifies the IF/ID contents (1 = real instruction, 0 = bubble).
//
// Modports:
//   master : the fetch stage (drives Address and IF/ID outputs)
//   slave  : the environment (drives control, returns Instruction)
interface instruction_fetch_stage_if;
  import pipeline_pkg::*;

  logic              Stall;
  logic              Flush;
  logic              Redirect;
  logic [WORD_W-1:0] RedirectPC;
  logic [WORD_W-1:0] Instruction;
  logic [WORD_W-1:0] Address;
  logic [WORD_W-1:0] IFID_Instruction;
  logic [WORD_W-1:0] IFID_PCPlus4;
  logic              IFID_Valid;

  modport master (
    input  Stall, Flush, Redirect, RedirectPC, Instruction,
    output Address, IFID_Instruction, IFID_PCPlus4, IFID_Valid
  );

  modport slave (
    output Stall, Flush, Redirect, RedirectPC, Instruction,
    input  Address, IFID_Instruction, IFID_PCPlus4, IFID_Valid
  );

endinterface

// File: rtl/instruction_fetch_stage_program_counter.sv
// program_counter: the fetch-stage PC register.
// Next-PC priority: reset > redirect > stall (hold) > PC+4.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   redirect         : load PC from redirect_pc (word-aligned)
//   redirect_pc      : target byte address
//   stall            : hold the PC
//   pc               : current PC
//   pc_plus4         : PC + 4 (wraps modulo 2^32)
module program_counter #(
  parameter logic [31:0] RESET_PC = pipeline_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  logic [31:0] pc_q;
  logic [31:0] pc_next;

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;

  // Redirect beats stall so a taken branch target is never dropped.
  // Low two bits are cleared to keep the PC word-aligned.
  always_comb begin
    pc_next = pc_plus4;
    if (redirect) begin
      pc_next = redirect_pc & ~32'h3;
    end else if (stall) begin
      pc_next = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC & ~32'h3;
    end else begin
      pc_q <= pc_next;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: MIPS IF stage. Drives the PC to instruction
// memory (external, combinational read) and captures the returned word
// with PC+4 and a valid bit into the IF/ID register.
// Ports:
//   Clk, Rst_n : clock, asynchronous active-low reset
//   bus        : instruction_fetch_stage_if.master (control in,
//                Instruction in, Address and IF/ID out)
//   FetchCount, StallCount : performance counters, present only when
//                FETCH_PERF_CNT_EN is defined
// IF/ID priority: reset > flush/redirect (bubble) > stall (hold) > load.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = pipeline_pkg::RESET_PC,
  parameter logic [31:0] NOP_WORD = pipeline_pkg::NOP_WORD
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  instruction_fetch_stage_if.master  bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                FetchCount,
  output logic [31:0]                StallCount
`endif
);
  import pipeline_pkg::*;

  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] pc_plus4;
  ifid_t             ifid_q;
  ifid_t             ifid_next;
  logic              bubble;
  logic              load;

  program_counter #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk         (Clk),
    .rst_n       (Rst_n),
    .redirect    (bus.Redirect),
    .redirect_pc (bus.RedirectPC),
    .stall       (bus.Stall),
    .pc          (pc),
    .pc_plus4    (pc_plus4)
  );

  assign bus.Address = pc;

  // A redirect squashes the wrong-path word fetched this cycle, so it
  // bubbles IF/ID exactly like an explicit flush.
  assign bubble = bus.Flush | bus.Redirect;
  assign load   = !bubble && !bus.Stall;

  always_comb begin
    ifid_next = ifid_q;
    if (bubble) begin
      ifid_next.instruction = NOP_WORD;
      ifid_next.pc_plus4    = pc_plus4;
      ifid_next.valid       = 1'b0;
    end else if (!bus.Stall) begin
      ifid_next.instruction = bus.Instruction;
      ifid_next.pc_plus4    = pc_plus4;
      ifid_next.valid       = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ifid_q.instruction <= NOP_WORD;
      ifid_q.pc_plus4    <= '0;
      ifid_q.valid       <= 1'b0;
    end else begin
      ifid_q <= ifid_next;
    end
  end

  assign bus.IFID_Instruction = ifid_q.instruction;
  assign bus.IFID_PCPlus4     = ifid_q.pc_plus4;
  assign bus.IFID_Valid       = ifid_q.valid;

`ifdef FETCH_PERF_CNT_EN
  // Stall cycles overridden by a redirect are not counted: the PC moved.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      FetchCount <= '0;
      StallCount <= '0;
    end else begin
      if (load) begin
        FetchCount <= FetchCount + 32'd1;
      end
      if (bus.Stall && !bus.Redirect) begin
        StallCount <= StallCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  instruction_fetch_stage_if bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCount;
  logic [31:0] StallCount;
`endif

  instruction_fetch_stage dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .bus        (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .FetchCount (FetchCount),
    .StallCount (StallCount)
`endif
  );

  // Bench instruction memory: word at index i is i*3, index = Address[8:2]
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] idx;
    idx = {25'd0, a[8:2]};
    return idx * 32'd3;
  endfunction

  assign bus.Instruction = mem_word(bus.Address);

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic [31:0] m_fetch_cnt;
  logic [31:0] m_stall_cnt;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".addr"},  bus.Address,          m_pc);
    check({tag, ".instr"}, bus.IFID_Instruction, m_instr);
    check({tag, ".pc4"},   bus.IFID_PCPlus4,     m_pc4);
    check({tag, ".valid"}, {31'd0, bus.IFID_Valid}, {31'd0, m_valid});
`ifdef FETCH_PERF_CNT_EN
    check({tag, ".fcnt"},  FetchCount, m_fetch_cnt);
    check({tag, ".scnt"},  StallCount, m_stall_cnt);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    Rst_n = 1'b0;
    bus.Stall = 1'b0;
    bus.Flush = 1'b0;
    bus.Redirect = 1'b0;
    bus.RedirectPC = '0;
    m_pc = 32'h0;
    m_instr = 32'h0;
    m_pc4 = 32'h0;
    m_valid = 1'b0;
    m_fetch_cnt = 0;
    m_stall_cnt = 0;
    @(negedge Clk);
    check_model("reset");
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  // One clock edge with the given controls; model follows the stated rules.
  task automatic step(input logic st, input logic fl, input logic rd, input logic [31:0] rpc);
    logic [31:0] next_pc4;
    bus.Stall = st;
    bus.Flush = fl;
    bus.Redirect = rd;
    bus.RedirectPC = rpc;
    @(posedge Clk);
    next_pc4 = m_pc + 32'd4;
    if (fl || rd) begin
      m_instr = 32'h0;
      m_pc4 = next_pc4;
      m_valid = 1'b0;
    end else if (!st) begin
      m_instr = mem_word(m_pc);
      m_pc4 = next_pc4;
      m_valid = 1'b1;
      m_fetch_cnt = m_fetch_cnt + 1;
    end
    if (st && !rd) m_stall_cnt = m_stall_cnt + 1;
    if (rd) m_pc = {rpc[31:2], 2'b00};
    else if (!st) m_pc = next_pc4;
    #1;
    check_model("step");
  endtask

  task automatic expect_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                             input logic vld);
    check({tag, ".instr"}, bus.IFID_Instruction, instr);
    check({tag, ".pc4"},   bus.IFID_PCPlus4,     pc4);
    check({tag, ".valid"}, {31'd0, bus.IFID_Valid}, {31'd0, vld});
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] exp_instr;
    logic [31:0] exp_pc4;

    // reset release then 4 free-running edges
    do_reset();
    check("reset.addr_const", bus.Address, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      exp_instr = 32'(i * 3);
      exp_pc4 = 32'(i * 4 + 4);
      expect_ifid("free", exp_instr, exp_pc4, 1'b1);
    end
    check("free.final_addr", bus.Address, 32'd16);

    // stall at PC=8
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check("stall.addr", bus.Address, 32'd8);
      expect_ifid("stall", 32'd3, 32'd8, 1'b1);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    expect_ifid("stall_release", 32'd6, 32'd12, 1'b1);

    // redirect at PC=12 to 0x43
    check("redir.pc12", bus.Address, 32'd12);
    step(1'b0, 1'b0, 1'b1, 32'h43);
    check("redir.addr", bus.Address, 32'h40);
    check("redir.bubble", {31'd0, bus.IFID_Valid}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    expect_ifid("redir.target", 32'd48, 32'h44, 1'b1);

    // redirect together with stall
    step(1'b1, 1'b0, 1'b1, 32'h20);
    check("redir_stall.addr", bus.Address, 32'h20);
    check("redir_stall.bubble", {31'd0, bus.IFID_Valid}, 32'd0);

    // flush together with stall: bubble, PC holds
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("flush_stall.addr", bus.Address, 32'h20);
    check("flush_stall.bubble", {31'd0, bus.IFID_Valid}, 32'd0);

    // wrap at top of address space
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    check("wrap.addr_top", bus.Address, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("wrap.addr", bus.Address, 32'h0);
    expect_ifid("wrap", 32'd381, 32'h0, 1'b1);

    // 5 fetches + 2 stalls, then async reset mid-cycle at PC=20
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("perf.fetch", FetchCount, 32'd5);
    check("perf.stall", StallCount, 32'd2);
`endif
    check("async.pc20", bus.Address, 32'd20);
    #2;
    Rst_n = 1'b0;
    #1;
    check("async.addr", bus.Address, 32'h0);
    check("async.valid", {31'd0, bus.IFID_Valid}, 32'd0);
    check("async.instr", bus.IFID_Instruction, 32'h0);
    check("async.pc4", bus.IFID_PCPlus4, 32'h0);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic st, fl, rd;
      logic [31:0] rpc;
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 7) == 0);
      rd = ($urandom_range(0, 7) == 0);
      rpc = $urandom;
      step(st, fl, rd, rpc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
